// File: rtl/neural_pkg.sv
// Shared constants, FSM state type and bus field helpers
// for the neuron multiply-accumulate datapath.
package neural_pkg;

    localparam int WIDTH     = 22;
    localparam int BUS_WIDTH = 16;
    localparam int MAX_TERMS = 64;
    localparam int TERM_W    = $clog2(MAX_TERMS);
    localparam int CNT_W     = TERM_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } mac_state_t;

    function automatic logic [7:0] get_weight(
        input logic [BUS_WIDTH-1:0] bus
    );
        return bus[15:8];
    endfunction

    function automatic logic [7:0] get_input(
        input logic [BUS_WIDTH-1:0] bus
    );
        return bus[7:0];
    endfunction

endpackage

// File: rtl/mac_product_stage.sv
// Registered unsigned 8x8 multiplier with a product-valid flag.
// The flag marks a product that the accumulator must add next cycle.
module mac_product_stage
    import neural_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        beat,
    input  logic [7:0]  weight,
    input  logic [7:0]  x,
    output logic [15:0] prod,
    output logic        prod_valid
);

    logic [15:0] prod_q, prod_d;
    logic        pv_q, pv_d;

    // Capture a new product on each accepted beat; start clears it
    always_comb begin
        prod_d = prod_q;
        pv_d   = beat;
        if (beat) begin
            prod_d = 16'(weight) * 16'(x);
        end
        if (clr) begin
            prod_d = '0;
            pv_d   = 1'b0;
        end
    end

    // Product and valid flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            pv_q   <= pv_d;
        end
    end

    assign prod       = prod_q;
    assign prod_valid = pv_q;

endmodule

// File: rtl/mac_unit.sv
// Neuron multiply-accumulate: sums num_terms weight*input products
// and holds the final sum on mac_output for the threshold comparator.
module mac_unit
    import neural_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TERM_W-1:0]    num_terms,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] input_bus,
    output logic [WIDTH-1:0]     mac_output,
    output logic                 mac_valid,
    output logic                 busy
);

    mac_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    logic             start_acc;
    logic             beat;
    logic [15:0]      prod;
    logic             prod_valid;
    logic [CNT_W-1:0] load_cnt;

    // Start is only honoured between neurons; ACCUM/DRAIN ignore it
    assign start_acc = start &&
                       (state_q == IDLE || state_q == DONE);
    assign in_ready  = (state_q == ACCUM) && (cnt_q != '0);
    assign beat      = in_valid && in_ready;
    assign busy      = (state_q == ACCUM) || (state_q == DRAIN);
    assign load_cnt  = (num_terms == '0) ?
                       CNT_W'(MAX_TERMS) :
                       {1'b0, num_terms};

    mac_product_stage u_prod (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .beat       (beat),
        .weight     (get_weight(input_bus)),
        .x          (get_input(input_bus)),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    // Next-state, counter, accumulator and result-latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        acc_d   = acc_q;
        if (prod_valid) begin
            acc_d = acc_q + WIDTH'(prod);
        end
        unique case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    cnt_d   = load_cnt;
                    acc_d   = '0;
                    valid_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // acc_d already includes the final product here
                out_d   = acc_d;
                valid_d = 1'b1;
                state_d = DONE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign mac_output = out_q;
    assign mac_valid  = valid_q;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: expected sums are queued at start,
// a negedge monitor pops them when mac_valid rises.
module tb_mac_unit;
    import neural_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  num_terms = '0;
    logic        in_valid = 1'b0;
    logic [15:0] input_bus = '0;
    logic        in_ready;
    logic [21:0] mac_output;
    logic        mac_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] exp_q[$];
    int          w_q[$];
    int          x_q[$];
    logic [21:0] last_exp = '0;

    mac_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_terms  (num_terms),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_bus  (input_bus),
        .mac_output (mac_output),
        .mac_valid  (mac_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Monitor: result compare on mac_valid rise, hold check otherwise
    logic        prev_valid = 1'b0;
    logic [21:0] prev_out = '0;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        if (rst || prev_rst) begin
        end else if (mac_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d with empty scoreboard",
                         mac_output);
            end else begin
                check("result", mac_output, exp_q.pop_front());
            end
        end else begin
            check("output_hold", mac_output, prev_out);
        end
        prev_valid = mac_valid;
        prev_out   = mac_output;
        prev_rst   = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_terms = n[5:0];
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", in_ready, 1);
        check("valid_low_after_start", mac_valid, 0);
    endtask

    task automatic send_beat(input int w, input int x);
        int waited = 0;
        in_valid  = 1'b1;
        input_bus = {w[7:0], x[7:0]};
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("beat_accept_timeout", in_ready, 1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Called just after the edge that accepted the last beat
    task automatic finish_run();
        check("ready_low_in_drain", in_ready, 0);
        check("busy_in_drain", busy, 1);
        check("valid_low_in_drain", mac_valid, 0);
        tick();
        check("valid_latency", mac_valid, 1);
        check("busy_low_done", busy, 0);
    endtask

    task automatic run_list(input int n, input int gapmax,
                            input bit mid_start, input bit extra);
        int sum = 0;
        int beats;
        beats = (n == 0) ? 64 : n;
        for (int i = 0; i < beats; i++) begin
            sum += w_q[i] * x_q[i];
        end
        exp_q.push_back(22'(sum));
        do_start(n);
        if (last_exp != '0) begin
            check("old_output_held", mac_output, last_exp);
        end
        for (int i = 0; i < beats; i++) begin
            if (i > 0) begin
                int g;
                g = $urandom_range(gapmax, 0);
                for (int k = 0; k < g; k++) begin
                    if (mid_start && k == 0) begin
                        start     = 1'b1;
                        num_terms = 6'($urandom_range(63, 1));
                        tick();
                        start = 1'b0;
                        check("busy_mid_start", busy, 1);
                        check("ready_mid_start", in_ready, 1);
                    end else begin
                        tick();
                    end
                end
            end
            send_beat(w_q[i], x_q[i]);
        end
        if (extra) begin
            in_valid  = 1'b1;
            input_bus = 16'h0101;
        end
        finish_run();
        if (extra) begin
            tick();
            check("extra_beat_ready", in_ready, 0);
            in_valid = 1'b0;
        end
        last_exp = 22'(sum);
        w_q.delete();
        x_q.delete();
    endtask

    initial begin
        int n;
        int beats;
        repeat (2) tick();
        check("rst_output", mac_output, 0);
        check("rst_valid", mac_valid, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        in_valid  = 1'b1;
        input_bus = 16'hFFFF;
        repeat (3) tick();
        check("idle_ready", in_ready, 0);
        check("idle_valid", mac_valid, 0);
        check("idle_output", mac_output, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        w_q = '{2, 4, 1};
        x_q = '{3, 5, 10};
        run_list(3, 0, 1'b0, 1'b0);
        check("three_term_sum", mac_output, 36);

        for (int i = 0; i < 64; i++) begin
            w_q.push_back(255);
            x_q.push_back(255);
        end
        run_list(0, 0, 1'b0, 1'b0);
        check("max_sum", mac_output, 22'h3F8040);

        w_q = '{1, 1, 1, 1};
        x_q = '{1, 1, 1, 1};
        run_list(4, 3, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            w_q.push_back(i + 3);
            x_q.push_back(2 * i + 1);
        end
        run_list(10, 2, 1'b1, 1'b0);

        w_q = '{9, 9, 9, 9, 9};
        x_q = '{9, 9, 9, 9, 9};
        do_start(5);
        send_beat(9, 9);
        send_beat(9, 9);
        rst = 1'b1;
        tick();
        check("midrst_output", mac_output, 0);
        check("midrst_valid", mac_valid, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        w_q.delete();
        x_q.delete();
        last_exp = '0;
        tick();

        w_q = '{3};
        x_q = '{7};
        run_list(1, 0, 1'b0, 1'b0);
        check("post_rst_sum", mac_output, 21);

        for (int r = 0; r < 15; r++) begin
            n     = $urandom_range(63, 0);
            beats = (n == 0) ? 64 : n;
            for (int i = 0; i < beats; i++) begin
                w_q.push_back($urandom_range(255, 0));
                x_q.push_back($urandom_range(255, 0));
            end
            repeat ($urandom_range(3, 0)) tick();
            run_list(n, 2, 1'($urandom_range(1, 0)), 1'b0);
        end

        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
